// File: rtl/student_dmux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package student_dmux_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_N     = 4;
    localparam int DEF_SELW  = 2;

    // True when the select value addresses a real channel.
    function automatic logic chan_ok(input logic [31:0] sel, input int unsigned n);
        return (sel < n);
    endfunction

endpackage

// File: rtl/student_dmux_stream_if.sv
// Bundles the producer-side and consumer-side stream signals of the demultiplexer.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the block, out_ready per channel from consumers.
interface student_dmux_stream_if
    import student_dmux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int SELW  = DEF_SELW
);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic [SELW-1:0]      sel;
    logic                 bcast;
    logic [N-1:0]         out_valid;
    logic [N-1:0]         out_ready;
    logic [N*WIDTH-1:0]   out_data;
    logic                 err_sel;

    // Producer and consumers drive the stream into the block.
    modport master (
        output in_valid, in_data, sel, bcast, out_ready,
        input  in_ready, out_valid, out_data, err_sel
    );

    // The demultiplexer itself.
    modport slave (
        input  in_valid, in_data, sel, bcast, out_ready,
        output in_ready, out_valid, out_data, err_sel
    );

endinterface

// File: rtl/student_dmux_slot.sv
// One output channel register: a valid flag plus its data word.
// Latency: load visible from the loading edge; drain clears valid at the edge.
// Backpressure: holds q stable while valid and not drained; load wins over drain.
module student_dmux_slot #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    logic             r_valid;
    logic [WIDTH-1:0] r_q;

    // Load replaces the word (even while draining) so a full slot streams with no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_q     <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_q     <= d;
        end else if (drain) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign q     = r_q;

endmodule

// File: rtl/student_dmux_stream.sv
// Routes one input stream to one of N channel registers, or to all of them on broadcast.
// Latency: accepted word appears on its channel from the accepting edge onward.
// Backpressure: in_ready follows the target slot(s) being free; bad selects are sunk.
module student_dmux_stream
    import student_dmux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int N     = DEF_N,
    parameter int SELW  = DEF_SELW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    student_dmux_stream_if.slave  bus
);

    logic [N-1:0]     w_free;
    logic [N-1:0]     w_load;
    logic [N-1:0]     w_drain;
    logic [N-1:0]     w_valid;
    logic [WIDTH-1:0] w_q [N];
    logic [31:0]      w_sel_u;
    logic             w_sel_ok;
    logic             w_sel_free;
    logic             w_all_free;
    logic             w_ready;
    logic             w_accept;
    logic             w_drop;
    logic             r_err_sel;

    // A slot can take new data when empty or when its consumer drains it this cycle.
    assign w_free     = ~w_valid | bus.out_ready;
    assign w_drain    = w_valid & bus.out_ready;
    assign w_all_free = &w_free;
    assign w_sel_u    = 32'(bus.sel);
    assign w_sel_ok   = chan_ok(w_sel_u, N);

    // Look up the free flag of the selected channel without indexing past N.
    always_comb begin
        w_sel_free = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (w_sel_u == i) begin
                w_sel_free = w_free[i];
            end
        end
    end

    // Ready: all slots for broadcast, the target slot for unicast, always for a bad select.
    always_comb begin
        w_ready = 1'b0;
        if (!rst_n) begin
            w_ready = 1'b0;
        end else if (bus.bcast) begin
            w_ready = w_all_free;
        end else if (w_sel_ok) begin
            w_ready = w_sel_free;
        end else begin
            w_ready = 1'b1;
        end
    end

    assign w_accept = bus.in_valid && w_ready;
    assign w_drop   = w_accept && !bus.bcast && !w_sel_ok;

    // Decode the accepted transfer into per-channel load strobes.
    always_comb begin
        w_load = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_load[i] = w_accept && (bus.bcast || (w_sel_u == i));
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_slot
        student_dmux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (w_load[gi]),
            .drain (w_drain[gi]),
            .d     (bus.in_data),
            .valid (w_valid[gi]),
            .q     (w_q[gi])
        );
    end

    // Pack the per-channel words onto the flat output bus.
    always_comb begin
        bus.out_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            bus.out_data[i*WIDTH +: WIDTH] = w_q[i];
        end
    end

    // Sticky record that a unicast with an out-of-range select was swallowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_sel <= 1'b0;
        end else if (w_drop) begin
            r_err_sel <= 1'b1;
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = w_valid;
    assign bus.err_sel   = r_err_sel;

endmodule

// File: tb/tb_student_dmux_stream.sv
// Directed bench for the stream demultiplexer with a per-channel scoreboard.
// Latency: n/a (testbench).
// Backpressure: out_ready patterns are driven per step.
module tb_student_dmux_stream;

    logic clk;
    logic rst_n;

    int checks;
    int errors;

    student_dmux_stream_if #(.WIDTH(8), .N(4), .SELW(2)) if4 ();
    student_dmux_stream_if #(.WIDTH(8), .N(3), .SELW(2)) if3 ();

    student_dmux_stream #(.WIDTH(8), .N(4), .SELW(2)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if4)
    );

    student_dmux_stream #(.WIDTH(8), .N(3), .SELW(2)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state for the 4-channel instance.
    logic [3:0] m_vld;
    logic [7:0] m_dat [4];
    logic [7:0] sb [4][$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive4(input logic v, input logic [7:0] d, input logic [1:0] s,
                          input logic b, input logic [3:0] ordy);
        if4.in_valid  = v;
        if4.in_data   = d;
        if4.sel       = s;
        if4.bcast     = b;
        if4.out_ready = ordy;
    endtask

    // One clock of the 4-channel instance: check ready, score drains, update model, check outputs.
    task automatic step4(input string tag);
        logic       exp_rdy;
        logic       acc;
        logic [3:0] free;
        logic [7:0] exp_d;
        #1;
        free = ~m_vld | if4.out_ready;
        if (if4.bcast)      exp_rdy = &free;
        else                exp_rdy = free[if4.sel];
        chk({tag, ".in_ready"}, 32'(if4.in_ready), 32'(exp_rdy));
        acc = if4.in_valid && exp_rdy;
        for (int i = 0; i < 4; i++) begin
            if (m_vld[i] && if4.out_ready[i]) begin
                chk({tag, ".sb_depth"}, sb[i].size(), 1);
                if (sb[i].size() > 0) begin
                    exp_d = sb[i].pop_front();
                    chk({tag, ".drain_data"}, 32'(if4.out_data[i*8 +: 8]), 32'(exp_d));
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (acc && (if4.bcast || (int'(if4.sel) == i))) begin
                m_vld[i] = 1'b1;
                m_dat[i] = if4.in_data;
                sb[i].push_back(if4.in_data);
            end else if (m_vld[i] && if4.out_ready[i]) begin
                m_vld[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 32'(if4.out_valid), 32'(m_vld));
        for (int i = 0; i < 4; i++) begin
            if (m_vld[i]) begin
                chk({tag, ".out_data"}, 32'(if4.out_data[i*8 +: 8]), 32'(m_dat[i]));
            end
        end
        chk({tag, ".err_sel"}, 32'(if4.err_sel), 0);
        @(negedge clk);
    endtask

    task automatic model_clear();
        m_vld = '0;
        for (int i = 0; i < 4; i++) begin
            m_dat[i] = '0;
            sb[i].delete();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_clear();

        // Reset held with a pending offer on both instances.
        rst_n = 1'b0;
        drive4(1'b1, 8'hFF, 2'd0, 1'b0, 4'hF);
        if3.in_valid  = 1'b1;
        if3.in_data   = 8'hEE;
        if3.sel       = 2'd0;
        if3.bcast     = 1'b0;
        if3.out_ready = 3'b111;
        #3;
        chk("rst.in_ready", 32'(if4.in_ready), 0);
        chk("rst.out_valid", 32'(if4.out_valid), 0);
        chk("rst.out_data", if4.out_data, 0);
        chk("rst.err_sel", 32'(if4.err_sel), 0);
        chk("rst3.in_ready", 32'(if3.in_ready), 0);

        @(negedge clk);
        rst_n = 1'b1;
        if3.in_valid = 1'b0;
        drive4(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);

        // Unicast sweep across all channels on consecutive cycles.
        for (int k = 0; k < 4; k++) begin
            drive4(1'b1, 8'(8'hA0 + k), 2'(k), 1'b0, 4'hF);
            step4("uni");
            chk("uni.chan_data", 32'(if4.out_data[k*8 +: 8]), 32'(8'hA0 + k));
        end

        // Back-pressure on channel 2.
        drive4(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        step4("bp.idle");
        drive4(1'b1, 8'h11, 2'd2, 1'b0, 4'b1011);
        step4("bp.first");
        drive4(1'b1, 8'h22, 2'd2, 1'b0, 4'b1011);
        step4("bp.stall");
        chk("bp.stall_rdy", 32'(if4.in_ready), 0);
        chk("bp.hold_data", 32'(if4.out_data[23:16]), 32'h11);
        drive4(1'b1, 8'h22, 2'd2, 1'b0, 4'hF);
        #1;
        chk("bp.release_rdy", 32'(if4.in_ready), 1);
        step4("bp.release");
        chk("bp.no_bubble", 32'(if4.out_valid[2]), 1);
        chk("bp.new_data", 32'(if4.out_data[23:16]), 32'h22);

        // Broadcast waits for every channel to be free.
        drive4(1'b1, 8'h5A, 2'd1, 1'b1, 4'b1011);
        step4("bc.wait0");
        step4("bc.wait1");
        chk("bc.wait_rdy", 32'(if4.in_ready), 0);
        drive4(1'b1, 8'h5A, 2'd1, 1'b1, 4'hF);
        step4("bc.go");
        chk("bc.all_valid", 32'(if4.out_valid), 32'hF);
        chk("bc.all_data", if4.out_data, 32'h5A5A_5A5A);

        // Bad select on the 3-channel instance.
        drive4(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        step4("bad.drain4");
        if3.in_valid = 1'b1;
        if3.in_data  = 8'h66;
        if3.sel      = 2'd3;
        if3.bcast    = 1'b0;
        #1;
        chk("bad.in_ready", 32'(if3.in_ready), 1);
        @(posedge clk);
        #1;
        chk("bad.out_valid", 32'(if3.out_valid), 0);
        chk("bad.err_set", 32'(if3.err_sel), 1);
        @(negedge clk);
        if3.in_data = 8'h77;
        if3.sel     = 2'd1;
        #1;
        chk("bad.next_rdy", 32'(if3.in_ready), 1);
        @(posedge clk);
        #1;
        chk("bad.next_valid", 32'(if3.out_valid), 32'b010);
        chk("bad.next_data", 32'(if3.out_data[15:8]), 32'h77);
        chk("bad.err_hold", 32'(if3.err_sel), 1);
        @(negedge clk);
        if3.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("bad.err_idle", 32'(if3.err_sel), 1);
        @(negedge clk);

        // Fill channels, then pulse reset between edges.
        drive4(1'b1, 8'h3C, 2'd0, 1'b1, 4'h0);
        step4("mid.fill");
        drive4(1'b0, 8'h00, 2'd0, 1'b0, 4'h0);
        step4("mid.hold");
        if3.out_ready = 3'b000;
        if3.in_valid  = 1'b1;
        if3.sel       = 2'd0;
        if3.in_data   = 8'h44;
        @(posedge clk);
        #1;
        chk("mid.fill3", 32'(if3.out_valid), 32'b001);
        if3.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid.out_valid4", 32'(if4.out_valid), 0);
        chk("mid.out_valid3", 32'(if3.out_valid), 0);
        chk("mid.err3", 32'(if3.err_sel), 0);
        chk("mid.in_ready", 32'(if4.in_ready), 0);
        #1;
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);

        // Traffic after reset.
        drive4(1'b1, 8'h99, 2'd1, 1'b0, 4'hF);
        step4("post.uni");
        chk("post.data", 32'(if4.out_data[15:8]), 32'h99);
        drive4(1'b1, 8'hC3, 2'd1, 1'b0, 4'hF);
        step4("post.stream");
        drive4(1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        step4("post.drain");
        for (int i = 0; i < 4; i++) begin
            chk("post.sb_empty", sb[i].size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
